uart_line_loader: RTL

Parametrised successor to the single-row UART receive controller. Parses framed row uploads from a host over a byte-level UART interface: sync, 2-byte row index, LINE_BYTES payload, checksum, end word. Writes the payload into an external line buffer through a write port instead of a flat vector. Adds block-level acknowledgement, checksum and row-range checking, inter-byte timeout and coded error responses. Sits between uart_receiver/uart_transmiter and the VGA line memory.

---
 rtl/uart_loader_pkg.sv | 30 +++
 rtl/uart_resp_sender.sv | 67 ++++++
 rtl/uart_line_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and default protocol codes for the UART row upload path.
// Used by the frame parser and its response sender.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROW_HI,
    ROW_LO,
    DATA,
    CSUM,
    END
  } state_t;

  localparam logic [7:0] DEF_SYNC_WORD   = 8'hA5;
  localparam logic [7:0] DEF_END_WORD    = 8'hDD;
  localparam logic [7:0] DEF_ACK_ROW     = 8'hCC;
  localparam logic [7:0] DEF_ACK_BLOCK   = 8'hAA;
  localparam logic [7:0] DEF_RESP_OK     = 8'hBC;
  localparam logic [7:0] DEF_ERR_END     = 8'h11;
  localparam logic [7:0] DEF_ERR_CSUM    = 8'h22;
  localparam logic [7:0] DEF_ERR_ROW     = 8'h33;
  localparam logic [7:0] DEF_ERR_TIMEOUT = 8'h44;

  // Bit width able to hold n distinct values, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    if (n <= 32'd2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/uart_resp_sender.sv
// Single-slot response queue: holds the newest response code, waits ACK_DELAY
// cycles and then for an idle transmitter before issuing a tx_start strobe.
module uart_resp_sender
  import uart_loader_pkg::*;
#(
  parameter int unsigned ACK_DELAY = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       q_valid,
  input  logic [7:0] q_code,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data
);

  localparam int unsigned    DLY_W    = width_of(ACK_DELAY + 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(ACK_DELAY);

  logic             pend_q, pend_d;
  logic [7:0]       code_q, code_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;

  // A new request always overwrites the slot and restarts the delay.
  always_comb begin
    pend_d     = pend_q;
    code_d     = code_q;
    dly_d      = dly_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    if (q_valid) begin
      pend_d = 1'b1;
      code_d = q_code;
      dly_d  = '0;
    end else if (pend_q) begin
      if (dly_q != DLY_LAST) begin
        dly_d = dly_q + 1'b1;
      end else if (!tx_busy) begin
        tx_start_d = 1'b1;
        tx_data_d  = code_q;
        pend_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 1'b0;
      code_q     <= '0;
      dly_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      pend_q     <= pend_d;
      code_q     <= code_d;
      dly_q      <= dly_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: rtl/uart_line_loader.sv
// Parses framed row uploads (sync, row, payload, checksum, end) from the UART
// byte stream, writes the payload into a line buffer and queues host responses.
module uart_line_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned LINE_BYTES     = 1920,
  parameter int unsigned ROW_MAX        = 479,
  parameter int unsigned ACK_EVERY      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned ACK_DELAY      = 16,
  parameter logic [7:0]  SYNC_WORD      = DEF_SYNC_WORD,
  parameter logic [7:0]  END_WORD       = DEF_END_WORD,
  parameter logic [7:0]  ACK_ROW        = DEF_ACK_ROW,
  parameter logic [7:0]  ACK_BLOCK      = DEF_ACK_BLOCK,
  parameter logic [7:0]  RESP_OK        = DEF_RESP_OK,
  parameter logic [7:0]  ERR_END        = DEF_ERR_END,
  parameter logic [7:0]  ERR_CSUM       = DEF_ERR_CSUM,
  parameter logic [7:0]  ERR_ROW        = DEF_ERR_ROW,
  parameter logic [7:0]  ERR_TIMEOUT    = DEF_ERR_TIMEOUT,
  localparam int unsigned ROW_W         = width_of(ROW_MAX + 1),
  localparam int unsigned ADDR_W        = width_of(LINE_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [ROW_W-1:0]  row,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        err_code,
  output logic              active
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned BLK_W = width_of(ACK_EVERY);
  localparam int unsigned TMO_W = width_of(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LINE_BYTES - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(ACK_EVERY - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]      ROW_LIMIT = 16'(ROW_MAX);

  state_t            state_q, state_d;
  logic [7:0]        row_hi_q, row_hi_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [7:0]        csum_q, csum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic              csum_err_q, csum_err_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        err_code_q, err_code_d;
  logic              resp_valid_q, resp_valid_d;
  logic [7:0]        resp_code_q, resp_code_d;

  logic [15:0] row_val;
  assign row_val = {row_hi_q, rx_data};

  // A received byte always beats a timeout expiring in the same cycle.
  always_comb begin
    state_d      = state_q;
    row_hi_d     = row_hi_q;
    row_d        = row_q;
    csum_d       = csum_q;
    cnt_d        = cnt_q;
    blk_d        = blk_q;
    csum_err_d   = csum_err_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    resp_valid_d = 1'b0;
    resp_code_d  = resp_code_q;

    if (state_q == IDLE || rx_valid) tmo_d = '0;
    else                             tmo_d = tmo_q + 1'b1;

    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data == SYNC_WORD) begin
            state_d    = ROW_HI;
            csum_d     = '0;
            cnt_d      = '0;
            blk_d      = '0;
            csum_err_d = 1'b0;
          end
        end
        ROW_HI: begin
          row_hi_d = rx_data;
          csum_d   = csum_q + rx_data;
          state_d  = ROW_LO;
        end
        ROW_LO: begin
          csum_d       = csum_q + rx_data;
          resp_valid_d = 1'b1;
          if (row_val > ROW_LIMIT) begin
            resp_code_d = ERR_ROW;
            err_code_d  = ERR_ROW;
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else begin
            row_d       = row_val[ROW_W-1:0];
            resp_code_d = ACK_ROW;
            state_d     = DATA;
          end
        end
        DATA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = rx_data;
          csum_d    = csum_q + rx_data;
          cnt_d     = cnt_q + 1'b1;
          // The final payload byte is acknowledged by the frame response instead.
          if (cnt_q == CNT_LAST) begin
            state_d = CSUM;
          end else if (blk_q == BLK_LAST) begin
            blk_d        = '0;
            resp_valid_d = 1'b1;
            resp_code_d  = ACK_BLOCK;
          end else begin
            blk_d = blk_q + 1'b1;
          end
        end
        CSUM: begin
          csum_err_d = (rx_data != csum_q);
          state_d    = END;
        end
        END: begin
          resp_valid_d = 1'b1;
          state_d      = IDLE;
          if (rx_data != END_WORD) begin
            resp_code_d = ERR_END;
            frame_err_d = 1'b1;
          end else if (csum_err_q) begin
            resp_code_d = ERR_CSUM;
            frame_err_d = 1'b1;
          end else begin
            resp_code_d  = RESP_OK;
            frame_done_d = 1'b1;
          end
          err_code_d = resp_code_d;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
      resp_valid_d = 1'b1;
      resp_code_d  = ERR_TIMEOUT;
      err_code_d   = ERR_TIMEOUT;
      frame_err_d  = 1'b1;
      state_d      = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_hi_q     <= '0;
      row_q        <= '0;
      csum_q       <= '0;
      cnt_q        <= '0;
      blk_q        <= '0;
      csum_err_q   <= 1'b0;
      tmo_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      row_hi_q     <= row_hi_d;
      row_q        <= row_d;
      csum_q       <= csum_d;
      cnt_q        <= cnt_d;
      blk_q        <= blk_d;
      csum_err_q   <= csum_err_d;
      tmo_q        <= tmo_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
      resp_valid_q <= resp_valid_d;
      resp_code_q  <= resp_code_d;
    end
  end

  uart_resp_sender #(
    .ACK_DELAY(ACK_DELAY)
  ) u_sender (
    .clk     (clk),
    .rst     (rst),
    .q_valid (resp_valid_q),
    .q_code  (resp_code_q),
    .tx_busy (tx_busy),
    .tx_start(tx_start),
    .tx_data (tx_data)
  );

  assign row        = row_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign active     = (state_q != IDLE);

endmodule
